// File: rtl/node_ram_arbiter.sv
// Round-robin arbiter sharing one single-port node RAM among NREQ requesters: gnt combinational, RAM port
// registered, rvalid RD_LAT+1 cycles after accept, no queuing (req holds until gnt). ARB_LOCK_EN adds grant lock.
module node_ram_arbiter #(
  parameter int NREQ     = 3,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 8
) (
  input  logic                     clk_50,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  input  logic [NREQ-1:0]          lock,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     ram_wen,
  output logic [ADDR_W-1:0]        ram_add,
  output logic [DATA_W-1:0]        ram_input,
  input  logic [DATA_W-1:0]        ram_output
);
  localparam int PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_win;
  logic [PTR_W-1:0] w_sel;
  logic [PTR_W-1:0] w_next;
  logic             w_any;
  logic             w_acc;
  logic [NREQ-1:0]  w_rr_gnt;
  logic [NREQ-1:0]  r_tag [RD_LAT+1];

  // First requester at or after the pointer, wrapping past NREQ-1.
  always_comb begin
    int idx;
    idx      = 0;
    w_rr_gnt = '0;
    w_win    = '0;
    w_any    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_any && req[idx]) begin
        w_any = 1'b1;
        w_win = PTR_W'(idx);
      end
    end
    if (w_any) w_rr_gnt[w_win] = 1'b1;
  end

`ifdef ARB_LOCK_EN
  localparam int CNT_W = (LOCK_MAX < 2) ? 1 : $clog2(LOCK_MAX + 1);
  typedef enum logic {UNLOCKED, LOCKED} lock_st_t;

  lock_st_t         r_st;
  logic [PTR_W-1:0] r_owner;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_lock_go;

  always_comb begin
    gnt = w_rr_gnt;
    if (r_st == LOCKED) begin
      gnt          = '0;
      gnt[r_owner] = req[r_owner];
    end
  end

  assign w_sel     = (r_st == LOCKED) ? r_owner : w_win;
  assign w_acc     = |gnt;
  assign w_cnt_nxt = (r_st == LOCKED) ? r_cnt + 1'b1 : CNT_W'(1);
  // The access that reaches LOCK_MAX still completes; the lock drops right after it.
  assign w_lock_go = lock[w_sel] && !((LOCK_MAX != 0) && (w_cnt_nxt >= CNT_W'(LOCK_MAX)));

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_st    <= UNLOCKED;
      r_owner <= '0;
      r_cnt   <= '0;
    end else if (w_acc) begin
      if (w_lock_go) begin
        r_st    <= LOCKED;
        r_owner <= w_sel;
        r_cnt   <= w_cnt_nxt;
      end else begin
        r_st  <= UNLOCKED;
        r_cnt <= '0;
      end
    end else if (r_st == LOCKED && !req[r_owner] && !lock[r_owner]) begin
      r_st  <= UNLOCKED;
      r_cnt <= '0;
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^lock;
  assign gnt           = w_rr_gnt;
  assign w_sel         = w_win;
  assign w_acc         = w_any;
`endif

  // While locked every accept is the owner, so the pointer stays at owner+1.
  assign w_next = (w_sel == PTR_W'(NREQ - 1)) ? '0 : w_sel + 1'b1;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= '0;
      ram_wen   <= 1'b0;
      ram_add   <= '0;
      ram_input <= '0;
    end else if (w_acc) begin
      r_ptr     <= w_next;
      ram_wen   <= we[w_sel];
      ram_add   <= addr[int'(w_sel)*ADDR_W +: ADDR_W];
      ram_input <= wdata[int'(w_sel)*DATA_W +: DATA_W];
    end else begin
      ram_wen <= 1'b0;
    end
  end

  // One-hot read tags follow the access through the RAM; writes enter as zero.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= RD_LAT; s++) r_tag[s] <= '0;
    end else begin
      r_tag[0] <= (w_acc && !we[w_sel]) ? gnt : '0;
      for (int s = 1; s <= RD_LAT; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  assign rvalid = r_tag[RD_LAT];
  assign rdata  = ram_output;

endmodule
